// File: rtl/config_int_add_acc_pipe.sv
// config_int_add_acc_pipe
// Two-stage integer adder / accumulator with run-time LSB truncation.
// Stage 1 captures the truncated operands, the mode and a valid bit.
// Stage 2 captures the result, the signed-overflow flag and out_valid.
// One global advance enable stalls both stages together under backpressure,
// so in-flight transactions are never lost, duplicated or reordered.
// The accumulator follows the stage-2 result of every mode-1 transaction.
// acc_clr acts in the cycle it is seen, whether or not the pipe advances.
module config_int_add_acc_pipe #(
    parameter int DATA_PATH_BITWIDTH = 32,
    parameter int MAX_APX_BITWIDTH   = 16,
    parameter int SATURATE           = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    in_valid,
    output logic                                    in_ready,
    input  logic [DATA_PATH_BITWIDTH-1:0]           a,
    input  logic [DATA_PATH_BITWIDTH-1:0]           b,
    input  logic [$clog2(DATA_PATH_BITWIDTH+1)-1:0] apx_bits,
    input  logic                                    mode,
    input  logic                                    acc_clr,
    output logic                                    out_valid,
    input  logic                                    out_ready,
    output logic [DATA_PATH_BITWIDTH-1:0]           c,
    output logic                                    ovf
);

    localparam int DW = DATA_PATH_BITWIDTH;
    localparam int AW = $clog2(DATA_PATH_BITWIDTH + 1);
    localparam logic [AW-1:0] MAXK = AW'(MAX_APX_BITWIDTH);

    // Effective truncation count: anything above MAXK (including counts
    // beyond the data width) silently falls back to MAXK.
    function automatic logic [AW-1:0] clamp_k(input logic [AW-1:0] k);
        logic [AW-1:0] r;
        if (k > MAXK) begin
            r = MAXK;
        end else begin
            r = k;
        end
        return r;
    endfunction

    // Mask that keeps the upper bits and zeroes the low k bits.
    function automatic logic [DW-1:0] trunc_mask(input logic [AW-1:0] k);
        return {DW{1'b1}} << k;
    endfunction

    // Signed overflow: operands agree in sign, the sum disagrees.
    function automatic logic add_ovf(input logic [DW-1:0] x,
                                     input logic [DW-1:0] y,
                                     input logic [DW-1:0] s);
        return (x[DW-1] == y[DW-1]) && (s[DW-1] != x[DW-1]);
    endfunction

    // Clamp value for an overflowing sum; neg selects the most negative value.
    function automatic logic [DW-1:0] sat_value(input logic neg);
        logic [DW-1:0] r;
        if (neg) begin
            r = {1'b1, {(DW-1){1'b0}}};
        end else begin
            r = {1'b0, {(DW-1){1'b1}}};
        end
        return r;
    endfunction

    // Handshake and enables
    logic          en_s;
    logic          in_ready_s;
    logic          accept_s;
    logic          adv_s;

    // Truncation
    logic [AW-1:0] keff_s;
    logic [DW-1:0] mask_s;

    // Stage 1
    logic          s1_valid_q, s1_valid_d;
    logic [DW-1:0] s1_a_q, s1_a_d;
    logic [DW-1:0] s1_b_q, s1_b_d;
    logic          s1_mode_q, s1_mode_d;

    // Stage-2 datapath
    logic [DW-1:0] op_x_s;
    logic [DW-1:0] sum_s;
    logic          ovf_s;
    logic [DW-1:0] res_s;

    // Stage 2 and accumulator
    logic          out_valid_q, out_valid_d;
    logic [DW-1:0] c_q, c_d;
    logic          ovf_q, ovf_d;
    logic [DW-1:0] acc_q, acc_d;

    // Global advance enable and the input/stage-1 handshakes derived from it.
    always_comb begin
        en_s       = !out_valid_q || out_ready;
        in_ready_s = en_s && !rst;
        accept_s   = in_valid && in_ready_s;
        adv_s      = en_s && s1_valid_q;
    end

    // Effective truncation count and operand mask for the incoming transaction.
    always_comb begin
        keff_s = clamp_k(apx_bits);
        mask_s = trunc_mask(keff_s);
    end

    // Stage-1 next state: load truncated operands on acceptance, hold on stall.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_mode_d  = s1_mode_q;
        if (en_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_a_d    = a & mask_s;
                s1_b_d    = b & mask_s;
                s1_mode_d = mode;
            end else begin
                s1_a_d    = s1_a_q;
                s1_b_d    = s1_b_q;
                s1_mode_d = s1_mode_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Stage-2 arithmetic: pick the second operand, add, detect and handle overflow.
    // A clear coinciding with a mode-1 update makes the accumulator read as zero.
    always_comb begin
        op_x_s = s1_b_q;
        if (s1_mode_q) begin
            if (acc_clr) begin
                op_x_s = {DW{1'b0}};
            end else begin
                op_x_s = acc_q;
            end
        end else begin
            op_x_s = s1_b_q;
        end
        sum_s = op_x_s + s1_a_q;
        ovf_s = add_ovf(op_x_s, s1_a_q, sum_s);
        if (ovf_s && (SATURATE != 0)) begin
            res_s = sat_value(s1_a_q[DW-1]);
        end else begin
            res_s = sum_s;
        end
    end

    // Stage-2 next state: capture the result when stage 1 advances, hold on stall.
    always_comb begin
        out_valid_d = out_valid_q;
        c_d         = c_q;
        ovf_d       = ovf_q;
        if (en_s) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                c_d   = res_s;
                ovf_d = ovf_s;
            end else begin
                c_d   = c_q;
                ovf_d = ovf_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Accumulator next state: follow mode-1 results, otherwise honour acc_clr.
    always_comb begin
        acc_d = acc_q;
        if (adv_s && s1_mode_q) begin
            acc_d = res_s;
        end else if (acc_clr) begin
            acc_d = {DW{1'b0}};
        end else begin
            acc_d = acc_q;
        end
    end

    // Stage-1 registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= {DW{1'b0}};
            s1_b_q     <= {DW{1'b0}};
            s1_mode_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            s1_mode_q  <= s1_mode_d;
        end
    end

    // Stage-2 registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            c_q         <= {DW{1'b0}};
            ovf_q       <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            c_q         <= c_d;
            ovf_q       <= ovf_d;
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {DW{1'b0}};
        end else begin
            acc_q <= acc_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_q;
    assign c         = c_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_config_int_add_acc_pipe.sv
// Bench for config_int_add_acc_pipe: a wrapping and a saturating instance
// share all inputs; directed vectors, hand-written corner sequences and a
// randomized phase checked against a plain-arithmetic reference model.
module tb_config_int_add_acc_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] a;
    logic [31:0] b;
    logic [5:0]  apx_bits;
    logic        mode;
    logic        acc_clr;
    logic        out_ready;

    logic        in_ready0, out_valid0, ovf0;
    logic        in_ready1, out_valid1, ovf1;
    logic [31:0] c0, c1;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  k;
        logic [31:0] c_wrap;
        logic        o_wrap;
        logic [31:0] c_sat;
        logic        o_sat;
    } vec_t;

    typedef struct {
        logic [31:0] c0;
        logic        o0;
        logic [31:0] c1;
        logic        o1;
    } exp_t;

    vec_t vecs[12];

    config_int_add_acc_pipe #(
        .DATA_PATH_BITWIDTH(32),
        .MAX_APX_BITWIDTH  (16),
        .SATURATE          (0)
    ) dut_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .apx_bits(apx_bits), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid0), .out_ready(out_ready), .c(c0), .ovf(ovf0)
    );

    config_int_add_acc_pipe #(
        .DATA_PATH_BITWIDTH(32),
        .MAX_APX_BITWIDTH  (16),
        .SATURATE          (1)
    ) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .apx_bits(apx_bits), .mode(mode), .acc_clr(acc_clr),
        .out_valid(out_valid1), .out_ready(out_ready), .c(c1), .ovf(ovf1)
    );

    // Free-running clock, 10 time-unit period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something wedges.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, req);
        end
    endtask

    // Reference: truncate, add as wide integers, range-check, wrap or clamp.
    function automatic void ref_add(input logic [31:0] x, input logic [31:0] y,
                                    input logic [5:0] k, input logic m, input bit sat,
                                    input logic [31:0] acc_in,
                                    output logic [31:0] res, output logic of);
        int          ke;
        logic [31:0] xt, yt;
        longint      s;
        if (k > 6'd16) ke = 16; else ke = int'(k);
        xt = (x >> ke) << ke;
        yt = (y >> ke) << ke;
        if (m) s = longint'($signed(acc_in)) + longint'($signed(xt));
        else   s = longint'($signed(xt)) + longint'($signed(yt));
        of = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        if (sat && of) res = (s > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
        else           res = s[31:0];
    endfunction

    function automatic logic [31:0] rand_operand();
        logic [31:0] r;
        case ($urandom_range(0, 3))
            0:       r = $urandom;
            1:       r = 32'h7FFF_FFFF - 32'($urandom_range(0, 65535));
            2:       r = 32'h8000_0000 + 32'($urandom_range(0, 65535));
            default: r = 32'($urandom_range(0, 1000));
        endcase
        return r;
    endfunction

    // One isolated transaction; checks both results and the 2-cycle latency.
    // clr_when: 0 no clear, 1 clear in the acceptance cycle, 2 clear while in stage 1.
    task automatic txn(input string nm, input logic [31:0] ta, input logic [31:0] tb_v,
                       input logic [5:0] tk, input logic tm, input int clr_when,
                       input logic [31:0] e0, input logic eo0,
                       input logic [31:0] e1, input logic eo1);
        int lat;
        in_valid = 1'b1; a = ta; b = tb_v; apx_bits = tk; mode = tm;
        acc_clr = (clr_when == 1); out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'h0; b = 32'h0; acc_clr = (clr_when == 2);
        lat = 1;
        while (!out_valid0 && lat < 8) begin
            @(posedge clk); #1;
            acc_clr = 1'b0;
            lat++;
        end
        acc_clr = 1'b0;
        @(negedge clk);
        check({nm, "_c_wrap"},   c0, e0);
        check({nm, "_ovf_wrap"}, ovf0, eo0);
        check({nm, "_c_sat"},    c1, e1);
        check({nm, "_ovf_sat"},  ovf1, eo1);
        check({nm, "_latency"},  lat, 2);
        @(posedge clk); #1;
    endtask

    task automatic backpressure();
        int sent = 0;
        int recv = 0;
        bit held_v = 0;
        logic [31:0] held_c = 32'h0;
        for (int i = 0; i < 20; i++) begin
            in_valid = (sent < 3); a = 32'(100 * (sent + 1)); b = 32'd1;
            apx_bits = 6'd0; mode = 1'b0; out_ready = (i >= 5);
            @(negedge clk);
            if (i == 2) begin
                check("bp_in_ready_low", in_ready0, 0);
                check("bp_out_valid_high", out_valid0, 1);
            end
            if (out_valid0 && !out_ready) begin
                if (held_v) check("bp_c_stable", c0, held_c);
                held_v = 1; held_c = c0;
            end else begin
                held_v = 0;
            end
            if (out_valid0 && out_ready) begin
                if (recv < 3) check($sformatf("bp_order%0d", recv), c0, 32'(100 * (recv + 1) + 1));
                else          check("bp_duplicate", c0, 32'h0);
                recv++;
            end
            if (in_valid && in_ready0) sent++;
            @(posedge clk); #1;
        end
        check("bp_sent", sent, 3);
        check("bp_recv", recv, 3);
    endtask

    task automatic random_phase(input int ncyc);
        exp_t        q[$];
        exp_t        e;
        logic [31:0] m0, m1, r, held;
        logic        o;
        bit          stall_prev, after_rst;
        m0 = 32'h0; m1 = 32'h0; held = 32'h0; stall_prev = 0; after_rst = 0;
        rst = 1'b1; in_valid = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < ncyc; i++) begin
            rst       = (i > 5) && ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 6);
            a = rand_operand(); b = rand_operand();
            apx_bits = 6'($urandom_range(0, 63));
            mode = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rnd_valid_match", out_valid1, out_valid0);
            check("rnd_ready_match", in_ready1, in_ready0);
            if (stall_prev) begin
                check("rnd_hold_c", c0, held);
                check("rnd_hold_valid", out_valid0, 1);
            end
            if (after_rst) check("rnd_rst_out_valid", out_valid0, 0);
            if (rst) begin
                check("rnd_rst_in_ready", in_ready0, 0);
                q.delete(); m0 = 32'h0; m1 = 32'h0;
                stall_prev = 0; after_rst = 1;
            end else begin
                if (after_rst) check("rnd_post_rst_in_ready", in_ready0, 1);
                after_rst = 0;
                stall_prev = out_valid0 && !out_ready;
                held = c0;
                if (out_valid0 && out_ready) begin
                    if (q.size() == 0) begin
                        check("rnd_unexpected_out", out_valid0, 0);
                    end else begin
                        e = q.pop_front();
                        check("rnd_c_wrap", c0, e.c0);
                        check("rnd_ovf_wrap", ovf0, e.o0);
                        check("rnd_c_sat", c1, e.c1);
                        check("rnd_ovf_sat", ovf1, e.o1);
                    end
                end
                if (in_valid && in_ready0) begin
                    ref_add(a, b, apx_bits, mode, 0, m0, r, o);
                    e.c0 = r; e.o0 = o;
                    if (mode) m0 = r;
                    ref_add(a, b, apx_bits, mode, 1, m1, r, o);
                    e.c1 = r; e.o1 = o;
                    if (mode) m1 = r;
                    q.push_back(e);
                end
            end
            @(posedge clk); #1;
        end
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            @(negedge clk);
            if (out_valid0 && q.size() != 0) begin
                e = q.pop_front();
                check("rnd_drain_c_wrap", c0, e.c0);
                check("rnd_drain_c_sat", c1, e.c1);
            end
            @(posedge clk); #1;
        end
        check("rnd_queue_empty", q.size(), 0);
    endtask

    initial begin
        vecs[0]  = '{32'd5,         32'hFFFF_FFFD, 6'd0,  32'd2,         1'b0, 32'd2,         1'b0};
        vecs[1]  = '{32'h0000_00FF, 32'h0000_0011, 6'd4,  32'h0000_0100, 1'b0, 32'h0000_0100, 1'b0};
        vecs[2]  = '{32'h0001_FFFF, 32'h0000_FFFF, 6'd20, 32'h0001_0000, 1'b0, 32'h0001_0000, 1'b0};
        vecs[3]  = '{32'h7FFF_FFFF, 32'h0000_0001, 6'd0,  32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'hFFFF_FFFF, 6'd0,  32'h7FFF_FFFF, 1'b1, 32'h8000_0000, 1'b1};
        vecs[5]  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd0,  32'hFFFF_FFFE, 1'b0, 32'hFFFF_FFFE, 1'b0};
        vecs[6]  = '{32'h1234_5678, 32'h0000_FFFF, 6'd40, 32'h1234_0000, 1'b0, 32'h1234_0000, 1'b0};
        vecs[7]  = '{32'h7FFF_8000, 32'h0001_0000, 6'd16, 32'h8000_0000, 1'b1, 32'h7FFF_FFFF, 1'b1};
        vecs[8]  = '{32'h7FFF_FFFF, 32'h0000_0001, 6'd1,  32'h7FFF_FFFE, 1'b0, 32'h7FFF_FFFE, 1'b0};
        vecs[9]  = '{32'h8000_0001, 32'h8000_0001, 6'd0,  32'h0000_0002, 1'b1, 32'h8000_0000, 1'b1};
        vecs[10] = '{32'h0001_2345, 32'h0005_4321, 6'd16, 32'h0006_0000, 1'b0, 32'h0006_0000, 1'b0};
        vecs[11] = '{32'hFFFF_8000, 32'hFFFF_7FFF, 6'd63, 32'hFFFE_0000, 1'b0, 32'hFFFE_0000, 1'b0};

        rst = 1'b1; in_valid = 1'b0; a = 32'h0; b = 32'h0; apx_bits = 6'd0;
        mode = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_in_ready", in_ready0, 0);
        check("reset_out_valid", out_valid0, 0);
        check("reset_c", c0, 32'h0);
        check("reset_ovf", ovf0, 0);
        check("reset_c_sat", c1, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", in_ready0, 1);
        @(posedge clk); #1;

        // Directed add vectors
        for (int i = 0; i < 12; i++) begin
            txn($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].k, 1'b0, 0,
                vecs[i].c_wrap, vecs[i].o_wrap, vecs[i].c_sat, vecs[i].o_sat);
        end

        // Backpressure
        backpressure();

        // Accumulate sequence
        acc_clr = 1'b1;
        @(posedge clk); #1;
        acc_clr = 1'b0;
        txn("acc10",   32'd10,   32'd0, 6'd0, 1'b1, 0, 32'd10,   1'b0, 32'd10,   1'b0);
        txn("acc20",   32'd20,   32'd0, 6'd0, 1'b1, 0, 32'd30,   1'b0, 32'd30,   1'b0);
        txn("add_mid", 32'd1000, 32'd5, 6'd0, 1'b0, 0, 32'd1005, 1'b0, 32'd1005, 1'b0);
        txn("acc30",   32'd30,   32'd0, 6'd0, 1'b1, 0, 32'd60,   1'b0, 32'd60,   1'b0);
        txn("clr7_in", 32'd7,    32'd0, 6'd0, 1'b1, 1, 32'd7,    1'b0, 32'd7,    1'b0);
        txn("acc3a",   32'd3,    32'd0, 6'd0, 1'b1, 0, 32'd10,   1'b0, 32'd10,   1'b0);
        txn("clr7_s1", 32'd7,    32'd0, 6'd0, 1'b1, 2, 32'd7,    1'b0, 32'd7,    1'b0);
        txn("acc3b",   32'd3,    32'd0, 6'd0, 1'b1, 0, 32'd10,   1'b0, 32'd10,   1'b0);
        txn("acc_trunc", 32'h35, 32'd0, 6'd4, 1'b1, 0, 32'h3A,   1'b0, 32'h3A,   1'b0);
        txn("acc_sat0", 32'h7FFF_FFF0, 32'd0, 6'd0, 1'b1, 1,
            32'h7FFF_FFF0, 1'b0, 32'h7FFF_FFF0, 1'b0);
        txn("acc_sat1", 32'h0000_0020, 32'd0, 6'd0, 1'b1, 0,
            32'h8000_0010, 1'b1, 32'h7FFF_FFFF, 1'b1);
        txn("acc_sat2", 32'hFFFF_FFFF, 32'd0, 6'd0, 1'b1, 0,
            32'h8000_000F, 1'b0, 32'h7FFF_FFFE, 1'b0);

        // Reset with two transactions in flight
        out_ready = 1'b1; mode = 1'b1; apx_bits = 6'd0; b = 32'h0;
        in_valid = 1'b1; a = 32'd100;
        @(posedge clk); #1;
        a = 32'd200;
        @(posedge clk); #1;
        in_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", in_ready0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", out_valid0, 0);
        check("midrst_c", c0, 32'h0);
        check("midrst_in_ready_after", in_ready0, 1);
        @(posedge clk); #1;
        txn("midrst_first", 32'd1, 32'd1, 6'd0, 1'b0, 0, 32'd2, 1'b0, 32'd2, 1'b0);
        txn("midrst_acc",   32'd5, 32'd0, 6'd0, 1'b1, 0, 32'd5, 1'b0, 32'd5, 1'b0);

        // Randomized phase against the reference model
        random_phase(1500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/config_int_add_acc_pipe.md
CONFIG_INT_ADD_ACC_PIPE -- requirements
Module: config_int_add_acc_pipe

Interface
REQ-001 The block SHALL have one clock, clk, and a synchronous, active-high reset, rst; all state changes SHALL occur on the rising edge of clk.
REQ-002 Parameter DATA_PATH_BITWIDTH, default 32: operand, result and accumulator width (DW).
REQ-003 Parameter MAX_APX_BITWIDTH, default 16: maximum number of truncated LSBs (MAXK); legal range 0..DW-1.
REQ-004 Parameter SATURATE, default 0: 0 = wrap on overflow, 1 = clamp on overflow.
REQ-005 clk  in  1  clock.
REQ-006 rst  in  1  synchronous reset, active high.
REQ-007 in_valid  in  1  an input transaction is present.
REQ-008 in_ready  out  1  the block accepts an input this cycle.
REQ-009 a  in  DW  signed operand A.
REQ-010 b  in  DW  signed operand B; ignored in accumulate mode.
REQ-011 apx_bits  in  clog2(DW+1)  runtime truncation count k.
REQ-012 mode  in  1  0 = add (a+b), 1 = accumulate (acc+a).
REQ-013 acc_clr  in  1  clears the accumulator.
REQ-014 out_valid  out  1  c and ovf hold a valid result.
REQ-015 out_ready  in  1  the downstream consumer accepts the result.
REQ-016 c  out  DW  signed result.
REQ-017 ovf  out  1  signed overflow occurred for this result.

Function
REQ-018 Global advance enable: en = !out_valid || out_ready; in_ready SHALL equal en && !rst; a transaction is accepted when in_valid && in_ready.
REQ-019 Pipeline: stage 1 registers the truncated operands, mode and a valid bit; stage 2 registers c, ovf and out_valid. Both stages SHALL hold all contents when en=0.
REQ-020 Latency: out_valid SHALL assert exactly 2 cycles after acceptance when en stays 1; one accepted input per cycle is sustainable.
REQ-021 Truncation: keff = min(apx_bits, MAXK), sampled at acceptance; the low keff bits of a and b SHALL be forced to 0 before the add, and therefore the low keff bits of c SHALL be 0 (accumulate mode excepted when acc carries nonzero low bits from an earlier, smaller keff).
REQ-022 Arithmetic is DW-bit two's complement. sum = a_t+b_t (mode 0) or acc+a_t (mode 1). ovf SHALL be set when the operands have equal signs and the sum's sign differs from them.
REQ-023 On overflow, SATURATE=0 SHALL output the wrapped sum; SATURATE=1 SHALL output 0x7FF..F for positive overflow and 0x800..0 for negative overflow.
REQ-024 acc SHALL be updated to the stage-2 output value (after saturation, if applied) only when a mode-1 transaction advances out of stage 1; mode-0 transactions SHALL leave acc unchanged.
REQ-025 acc_clr: when it coincides with a mode-1 stage-2 update, the result SHALL be 0+a_t and acc SHALL take that value; otherwise acc SHALL become 0. acc_clr SHALL act regardless of en.
REQ-026 While en=0, in-flight data SHALL NOT be lost, duplicated or reordered; c and ovf SHALL stay stable while out_valid=1 and out_ready=0.
REQ-027 An out-of-range apx_bits (> MAXK, including > DW-1) SHALL clamp to MAXK; no error indication is generated.

Reset
REQ-028 While rst=1 at a clock edge: both valid bits, out_valid, c, ovf and acc SHALL become 0, and in_ready SHALL be 0.
REQ-029 Reset mid-operation SHALL discard all in-flight transactions; out_valid SHALL be 0 in the cycle after the reset edge, and in_ready SHALL be 1 in the first cycle in which rst=0.

Verification
REQ-030 With DW=32, MAXK=16, apx_bits=0, mode=0, a=5, b=-3: c must be 2 with ovf=0, and out_valid must assert 2 cycles after acceptance.
REQ-031 Truncation: apx_bits=4, a=0x000000FF, b=0x00000011 -> c=0x00000100; apx_bits=20 (clamped to 16), a=0x0001FFFF, b=0x0000FFFF -> c=0x00010000.
REQ-032 Overflow: apx_bits=0, a=0x7FFFFFFF, b=1 -> c=0x80000000 and ovf=1 with SATURATE=0; c=0x7FFFFFFF and ovf=1 with SATURATE=1. Also with SATURATE=1: a=0x80000000, b=-1 -> c=0x80000000, ovf=1.
REQ-033 Backpressure: stream 3 transactions while out_ready=0 for 5 cycles -> in_ready must drop once both stages are full, c must be held stable, and all 3 results must appear in order with none lost or duplicated.
REQ-034 Accumulate: acc_clr, then mode=1 with a=10, 20, 30 -> c=10, 30, 60; acc_clr together with a=7 -> c=7; a mode-0 add in between must not disturb acc.
REQ-035 Reset asserted with 2 transactions in flight -> out_valid=0 on the next cycle, acc=0, and the first post-reset transaction a=1, b=1 -> c=2.
